// File: rtl/rsa_ctrl_seq_if.sv
// Command/status bundle between the GPIO/SPI front end, the sequencer and the rsa_unit bank.
// The master modport is the front-end/unit side; the slave modport is the sequencer side.
interface rsa_ctrl_seq_if #(
    parameter int NUM_CH = 2,
    parameter int TMO_W  = 16
);
    logic              ena;
    logic [NUM_CH-1:0] gpio_start;
    logic [NUM_CH-1:0] spi_start;
    logic [NUM_CH-1:0] gpio_stop;
    logic [NUM_CH-1:0] spi_stop;
    logic [NUM_CH-1:0] eoc_clr;
    logic [TMO_W-1:0]  tmo_limit;
    logic [NUM_CH-1:0] eoc_rsa_unit;
    logic [NUM_CH-1:0] en_rsa;
    logic [NUM_CH-1:0] rst_rsa;
    logic [NUM_CH-1:0] eoc;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] tmo_err;

    modport master (
        output ena, gpio_start, spi_start, gpio_stop, spi_stop, eoc_clr, tmo_limit, eoc_rsa_unit,
        input  en_rsa, rst_rsa, eoc, busy, tmo_err
    );
    modport slave (
        input  ena, gpio_start, spi_start, gpio_stop, spi_stop, eoc_clr, tmo_limit, eoc_rsa_unit,
        output en_rsa, rst_rsa, eoc, busy, tmo_err
    );
endinterface

// File: rtl/rsa_ctrl_seq.sv
// Multi-channel enable/reset-release sequencer for a bank of RSA units.
// One independent rsa_ctrl_ch per channel; the watchdog limit is shared by all channels.
module rsa_ctrl_ch #(
    parameter int RST_DLY    = 2,
    parameter int TMO_W      = 16,
    parameter int STOP_MODE  = 0,
    parameter int EOC_STICKY = 0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic             stop_g,
    input  logic             stop_s,
    input  logic             eoc_clr,
    input  logic [TMO_W-1:0] tmo_limit,
    input  logic             eoc_unit,
    output logic             en,
    output logic             rst,
    output logic             eoc,
    output logic             busy,
    output logic             tmo_err
);
    localparam int DW = (RST_DLY > 1) ? $clog2(RST_DLY) : 1;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_IDLE  = 3'd1,
        S_EN    = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } st_t;

    st_t              st, st_nx;
    logic [DW-1:0]    dly_cnt;
    logic [TMO_W-1:0] wd_cnt;
    logic             hold, terr;
    logic             stop, wd_hit, is_done;

    assign stop   = (STOP_MODE != 0) ? (stop_g | stop_s) : (stop_g & stop_s);
    assign wd_hit = (tmo_limit != '0) && (wd_cnt == tmo_limit - TMO_W'(1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)    st <= S_RESET;
        else if (ena) st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            S_RESET: st_nx = S_IDLE;
            S_IDLE:  if (start) st_nx = S_EN;
            S_EN: begin
                if (stop)                 st_nx = S_IDLE;
                else if (dly_cnt == '0)   st_nx = S_RUN;
            end
            S_RUN: begin
                if (stop)          st_nx = S_IDLE;
                else if (eoc_unit) st_nx = S_DONE;
                else if (wd_hit)   st_nx = S_IDLE;
            end
            S_DONE:  st_nx = S_IDLE;
            default: st_nx = S_RESET;
        endcase
    end

    always_comb begin
        en      = 1'b0;
        rst     = 1'b0;
        busy    = 1'b0;
        is_done = 1'b0;
        case (st)
            S_EN:   begin en = 1'b1; busy = 1'b1; end
            S_RUN:  begin en = 1'b1; rst = 1'b1; busy = 1'b1; end
            S_DONE: begin en = 1'b1; rst = 1'b1; busy = 1'b1; is_done = 1'b1; end
            default: ;
        endcase
    end

    assign eoc     = (EOC_STICKY != 0) ? (is_done | hold) : is_done;
    assign tmo_err = terr;

    // Watchdog is zeroed throughout EN so RUN always starts counting from 0.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            dly_cnt <= '0;
            wd_cnt  <= '0;
        end else if (ena) begin
            case (st)
                S_IDLE: if (start) dly_cnt <= DW'(RST_DLY - 1);
                S_EN: begin
                    wd_cnt <= '0;
                    if (dly_cnt != '0) dly_cnt <= dly_cnt - DW'(1);
                end
                S_RUN:  if (wd_cnt != '1) wd_cnt <= wd_cnt + TMO_W'(1);
                default: ;
            endcase
        end
    end

    // Sets are tested first so they win over a same-cycle eoc_clr.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hold <= 1'b0;
            terr <= 1'b0;
        end else if (ena) begin
            if (st == S_DONE)
                hold <= 1'b1;
            else if (eoc_clr || (st == S_IDLE && start))
                hold <= 1'b0;
            if (st == S_RUN && !stop && !eoc_unit && wd_hit)
                terr <= 1'b1;
            else if (eoc_clr || (st == S_IDLE && start))
                terr <= 1'b0;
        end
    end
endmodule

module rsa_ctrl_seq #(
    parameter int NUM_CH     = 2,
    parameter int RST_DLY    = 2,
    parameter int TMO_W      = 16,
    parameter int STOP_MODE  = 0,
    parameter int EOC_STICKY = 0
) (
    input  logic           clk,
    input  logic           rstb,
    rsa_ctrl_seq_if.slave  bus
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rsa_ctrl_ch #(
            .RST_DLY    (RST_DLY),
            .TMO_W      (TMO_W),
            .STOP_MODE  (STOP_MODE),
            .EOC_STICKY (EOC_STICKY)
        ) u_ch (
            .clk       (clk),
            .rstb      (rstb),
            .ena       (bus.ena),
            .start     (bus.gpio_start[i] | bus.spi_start[i]),
            .stop_g    (bus.gpio_stop[i]),
            .stop_s    (bus.spi_stop[i]),
            .eoc_clr   (bus.eoc_clr[i]),
            .tmo_limit (bus.tmo_limit),
            .eoc_unit  (bus.eoc_rsa_unit[i]),
            .en        (bus.en_rsa[i]),
            .rst       (bus.rst_rsa[i]),
            .eoc       (bus.eoc[i]),
            .busy      (bus.busy[i]),
            .tmo_err   (bus.tmo_err[i])
        );
    end
endmodule
